axis_rr_arbiter: RTL and testbench

//  Packet-aware round-robin arbiter: merges NUM_SRC AXI-Stream masters onto one AXI-Stream output.
//  A grant is held from the first beat to the tlast beat, so packets never interleave.

---
 rtl/axis_pkg.sv | 29 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/axis_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream arbitration blocks.
//   IDLE / BUSY : arbiter FSM state encodings
//   CNT_W       : width of the optional per-source packet counters
//   clog2       : constant-evaluable ceiling log2, used to size grant indices
// ---------------------------------------------------------------------------
package axis_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int CNT_W = 32;

  // Smallest r such that 2**r >= value (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req starting one position
// after last_ptr and wrapping modulo NUM_SRC; reports the first hit.
// Ports:
//   req      in   NUM_SRC  request vector
//   last_ptr in   IDW      index that won most recently (lowest priority now)
//   any      out  1        at least one request is set
//   idx      out  IDW      winning index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDW     = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDW-1:0]     last_ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_ptr is the value left standing when the loop finishes.
  always_comb begin
    any  = 1'b0;
    idx  = {IDW{1'b0}};
    cand = {IDW{1'b0}};
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = IDW'((int'(last_ptr) + k) % NUM_SRC);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-aware round-robin arbiter merging NUM_SRC AXI-Stream masters onto
// one AXI-Stream output. A grant is held from the first beat through the
// tlast beat, so packets never interleave. One idle (arbitration) cycle is
// spent between packets; while BUSY the granted source is passed through
// combinationally with zero latency.
//
// Optional feature macro: AXIS_ARB_STATS_EN adds per-source 32-bit packet
// counters on port pkt_cnt (counter i at bits [i*32 +: 32]).
//
// Ports:
//   clk            in   1                  clock, posedge
//   rst            in   1                  synchronous reset, active-high
//   s_axis_tdata   in   NUM_SRC*DATAWIDTH  source i at [i*DATAWIDTH +: DATAWIDTH]
//   s_axis_tvalid  in   NUM_SRC            per-source valid
//   s_axis_tlast   in   NUM_SRC            per-source end of packet
//   s_axis_tready  out  NUM_SRC            per-source ready, one-hot or zero
//   m_axis_tdata   out  DATAWIDTH          merged data
//   m_axis_tvalid  out  1                  merged valid
//   m_axis_tlast   out  1                  merged last
//   m_axis_tid     out  IDW                index of granted source
//   m_axis_tready  in   1                  downstream ready
//   pkt_cnt        out  NUM_SRC*32         (AXIS_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int NUM_SRC   = 4,
  parameter int IDW       = clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*DATAWIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  output logic [DATAWIDTH-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic [IDW-1:0]                 m_axis_tid,
  input  logic                           m_axis_tready
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_SRC*CNT_W-1:0]       pkt_cnt
`endif
);

  logic [0:0]           state;
  logic [IDW-1:0]       grant;
  logic [IDW-1:0]       last_ptr;
  logic                 pick_any;
  logic [IDW-1:0]       pick_idx;
  logic                 last_beat;
  logic [DATAWIDTH-1:0] src_data [NUM_SRC];

  // Unpacked view of the flat data bus so the output mux indexes by grant.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_data[g] = s_axis_tdata[g*DATAWIDTH +: DATAWIDTH];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_pick (
    .req      (s_axis_tvalid),
    .last_ptr (last_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Final handshake of the granted packet; ends the grant.
  assign last_beat = (state == BUSY) & s_axis_tvalid[grant] & m_axis_tready
                     & s_axis_tlast[grant];

  // Arbitration FSM: pick in IDLE, hold the grant in BUSY until tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= {IDW{1'b0}};
      last_ptr <= IDW'(NUM_SRC - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (last_beat) begin
            last_ptr <= grant;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output pass-through; tvalid depends only on state and source valid,
  // never on m_axis_tready.
  always_comb begin
    m_axis_tdata = src_data[grant];
    m_axis_tlast = s_axis_tlast[grant];
    m_axis_tid   = grant;
    if (state == BUSY) begin
      m_axis_tvalid = s_axis_tvalid[grant];
      s_axis_tready = {{(NUM_SRC-1){1'b0}}, m_axis_tready} << grant;
    end else begin
      m_axis_tvalid = 1'b0;
      s_axis_tready = {NUM_SRC{1'b0}};
    end
  end

`ifdef AXIS_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_SRC];

  // Per-source completed-packet counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (last_beat && (grant == IDW'(i))) begin
          cnt[i] <= cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_pack
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed bench for axis_rr_arbiter (NUM_SRC=4, DATAWIDTH=64). Sources are
// queues of beats that pop on handshake; a packet-level ownership model
// predicts the output side every cycle, and each scenario pins the accepted
// beat order and timing against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int N     = 4;
  localparam int W     = 64;
  localparam int IDW   = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N*W-1:0] s_tdata = '0;
  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tlast = '0;
  logic [N-1:0]   s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic [IDW-1:0] m_tid;
  logic           m_tready = 1'b1;
`ifdef AXIS_ARB_STATS_EN
  logic [N*32-1:0] pkt_cnt;
`endif

  axis_rr_arbiter #(.DATAWIDTH(W), .NUM_SRC(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tready (m_tready)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  // Source beat queues
  logic [W-1:0] qd [N][DEPTH];
  logic         ql [N][DEPTH];
  int           qh [N];
  int           qt [N];
  logic [N-1:0] hold = '0;
  logic [W-1:0] cur_data [N];

  // Accepted-beat log on the master side
  int           log_src [$];
  logic [W-1:0] log_dat [$];
  int           log_cyc [$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic toggle = 1'b0;
  logic armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int tag, input int s, input int b);
    return 64'(tag * 65536 + s * 256 + b);
  endfunction

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      if (qh[s] < qt[s]) begin
        cur_data[s]        = qd[s][qh[s]];
        s_tdata[s*W +: W]  = qd[s][qh[s]];
        s_tlast[s]         = ql[s][qh[s]];
        s_tvalid[s]        = !hold[s];
      end else begin
        cur_data[s]        = '0;
        s_tdata[s*W +: W]  = '0;
        s_tlast[s]         = 1'b0;
        s_tvalid[s]        = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int s, input int tag, input int n);
    for (int b = 0; b < n; b++) begin
      qd[s][qt[s]] = mk(tag, s, b);
      ql[s][qt[s]] = (b == n - 1);
      qt[s]++;
    end
    drive();
  endtask

  // One clock: observe handshakes mid-cycle, then advance sources after the edge.
  task automatic cycle();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = (!rst) ? (s_tvalid & s_tready) : '0;
    if (!rst && m_tvalid && m_tready) begin
      log_src.push_back(int'(m_tid));
      log_dat.push_back(m_tdata);
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) begin
      if (fire[s]) qh[s]++;
    end
    cyc++;
    if (toggle) m_tready = ~m_tready;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold = '0;
    toggle = 1'b0;
    for (int s = 0; s < N; s++) begin
      qh[s] = 0;
      qt[s] = 0;
    end
    log_src.delete();
    log_dat.delete();
    log_cyc.delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    armed = 1'b1;
    cyc++;
  endtask

  // Settled look at the outputs, taken from the post-edge drive point.
  task automatic peek();
    #2;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (log_src.size() < n && k < budget) begin
      cycle();
      k++;
    end
    checks++;
    if (log_src.size() < n) begin
      failures++;
      $display("FAIL %s timeout beats=%0d required=%0d", name, log_src.size(), n);
    end
  endtask

  task automatic check_beat(input string name, input int i, input int s, input int tag, input int b);
    if (i < log_src.size()) begin
      check({name, "_src"}, 64'(log_src[i]), 64'(s));
      check({name, "_data"}, log_dat[i], mk(tag, s, b));
    end else begin
      checks++;
      failures++;
      $display("FAIL %s missing beat index=%0d logged=%0d", name, i, log_src.size());
    end
  endtask

  task automatic check_gap(input string name, input int i, input int gap);
    if (i + 1 < log_cyc.size()) begin
      check(name, 64'(log_cyc[i+1] - log_cyc[i]), 64'(gap));
    end else begin
      checks++;
      failures++;
      $display("FAIL %s missing beats for gap index=%0d", name, i);
    end
  endtask

  // Ownership model: who holds the output, and who won last.
  int mown = -1;
  int mlast = N - 1;
  always @(posedge clk) begin : model_blk
    int pick;
    pick = -1;
    if (rst) begin
      mown  <= -1;
      mlast <= N - 1;
    end else if (mown < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && s_tvalid[(mlast + k) % N]) pick = (mlast + k) % N;
      end
      mown <= pick;
    end else if (s_tvalid[mown] && m_tready && s_tlast[mown]) begin
      mown  <= -1;
      mlast <= mown;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst && armed) begin
      if (mown < 0) begin
        check("idle_m_tvalid", 64'(m_tvalid), 64'(0));
        check("idle_s_tready", 64'(s_tready), 64'(0));
      end else begin
        check("busy_m_tvalid", 64'(m_tvalid), 64'(s_tvalid[mown]));
        check("busy_s_tready", 64'(s_tready), m_tready ? (64'(1) << mown) : 64'(0));
        check("busy_m_tid", 64'(m_tid), 64'(mown));
        if (s_tvalid[mown]) begin
          check("busy_m_tdata", m_tdata, cur_data[mown]);
          check("busy_m_tlast", 64'(m_tlast), 64'(s_tlast[mown]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then a 3-beat packet from source 0
    do_reset();
    peek();
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_m_tid", 64'(m_tid), 64'(0));
    m_tready = 1'b1;
    push_pkt(0, 1, 3);
    wait_log(3, 20, "t1_wait");
    check_beat("t1_b0", 0, 0, 1, 0);
    check_beat("t1_b1", 1, 0, 1, 1);
    check_beat("t1_b2", 2, 0, 1, 2);
    check_gap("t1_gap01", 0, 1);
    check_gap("t1_gap12", 1, 1);
    peek();
    check("t1_after_tvalid", 64'(m_tvalid), 64'(0));
`ifdef AXIS_ARB_STATS_EN
    check("t1_pkt_cnt0", 64'(pkt_cnt[31:0]), 64'(1));
`endif

    // 2: all four sources with 2-beat packets, source 0 has a second one
    do_reset();
    m_tready = 1'b1;
    push_pkt(0, 2, 2);
    push_pkt(1, 2, 2);
    push_pkt(2, 2, 2);
    push_pkt(3, 2, 2);
    push_pkt(0, 3, 2);
    wait_log(10, 60, "t2_wait");
    for (int s = 0; s < N; s++) begin
      check_beat("t2_pa", 2 * s, s, 2, 0);
      check_beat("t2_pb", 2 * s + 1, s, 2, 1);
    end
    check_beat("t2_r0a", 8, 0, 3, 0);
    check_beat("t2_r0b", 9, 0, 3, 1);

    // 3: source 1 with downstream ready toggling
    do_reset();
    push_pkt(1, 4, 4);
    m_tready = 1'b1;
    toggle = 1'b1;
    wait_log(4, 40, "t3_wait");
    toggle = 1'b0;
    m_tready = 1'b1;
    for (int b = 0; b < 4; b++) check_beat("t3_beat", b, 1, 4, b);
    cycle();
    cycle();
    cycle();
    check("t3_no_dup", 64'(log_src.size()), 64'(4));

    // 4: wrap after source 3 wins; single-beat packets
    do_reset();
    m_tready = 1'b1;
    push_pkt(3, 5, 1);
    wait_log(1, 20, "t4_first");
    push_pkt(3, 6, 1);
    push_pkt(0, 6, 1);
    wait_log(3, 20, "t4_wait");
    check_beat("t4_first", 0, 3, 5, 0);
    check_beat("t4_wrap", 1, 0, 6, 0);
    check_beat("t4_next", 2, 3, 6, 0);
    check_gap("t4_gap_a", 0, 2);
    check_gap("t4_gap_b", 1, 2);

    // 5: reset in the middle of a 4-beat packet
    do_reset();
    m_tready = 1'b1;
    push_pkt(1, 7, 4);
    wait_log(2, 20, "t5_mid");
    do_reset();
    peek();
    check("t5_m_tvalid", 64'(m_tvalid), 64'(0));
    check("t5_s_tready", 64'(s_tready), 64'(0));
`ifdef AXIS_ARB_STATS_EN
    check("t5_pkt_cnt", 64'(pkt_cnt[63:0]), 64'(0));
`endif
    push_pkt(3, 8, 1);
    push_pkt(2, 8, 1);
    wait_log(2, 20, "t5_wait");
    check_beat("t5_low", 0, 2, 8, 0);
    check_beat("t5_next", 1, 3, 8, 0);

    // 6: granted source 2 stalls while source 0 waits
    do_reset();
    m_tready = 1'b1;
    push_pkt(2, 9, 3);
    wait_log(1, 20, "t6_first");
    hold[2] = 1'b1;
    push_pkt(0, 9, 1);
    for (int i = 0; i < 5; i++) begin
      peek();
      check("t6_tid", 64'(m_tid), 64'(2));
      check("t6_s_tready0", 64'(s_tready[0]), 64'(0));
      check("t6_m_tvalid", 64'(m_tvalid), 64'(0));
      cycle();
    end
    hold[2] = 1'b0;
    drive();
    wait_log(4, 30, "t6_wait");
    check_beat("t6_b0", 0, 2, 9, 0);
    check_beat("t6_b1", 1, 2, 9, 1);
    check_beat("t6_b2", 2, 2, 9, 2);
    check_beat("t6_src0", 3, 0, 9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
